// File: rtl/rdata_stream_packetizer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rdata_stream_packetizer
// Purpose  : Buffers unthrottled DDR4 read beats and frames them onto an
//            AXI-Stream master with tkeep/tlast and FIFO-pressure reporting.
// Revision : 1.0 - initial release
// ============================================================================
module rdata_stream_packetizer #(
  parameter int DATA_WIDTH   = 512,
  parameter int FIFO_DEPTH   = 64,
  parameter int AFULL_MARGIN = 8,
  parameter int LEN_WIDTH    = 16
) (
  input  logic                    c0_ddr4_clk,
  input  logic                    c0_ddr4_rst,
  input  logic                    rd_valid,
  input  logic [DATA_WIDTH-1:0]   rd_data,
  input  logic [LEN_WIDTH-1:0]    pkt_len,
  input  logic                    flush,
  input  logic                    clr_err,
  output logic [DATA_WIDTH-1:0]   M_AXIS_RDATA_tdata,
  output logic [DATA_WIDTH/8-1:0] M_AXIS_RDATA_tkeep,
  output logic                    M_AXIS_RDATA_tlast,
  output logic                    M_AXIS_RDATA_tvalid,
  input  logic                    M_AXIS_RDATA_tready,
  output logic                    rd_afull,
  output logic                    overflow,
  output logic [LEN_WIDTH-1:0]    pkt_count
);

  localparam int c_KEEP_W = DATA_WIDTH / 8;
  localparam int c_AW     = $clog2(FIFO_DEPTH);
  localparam int c_CW     = c_AW + 1;
  localparam logic [c_CW-1:0]      c_FULL_LEVEL  = c_CW'(FIFO_DEPTH);
  localparam logic [c_CW-1:0]      c_AFULL_LEVEL = c_CW'(FIFO_DEPTH - AFULL_MARGIN);
  localparam logic [c_CW-1:0]      c_CNT_ONE     = c_CW'(1);
  localparam logic [c_AW-1:0]      c_PTR_ONE     = c_AW'(1);
  localparam logic [LEN_WIDTH-1:0] c_LEN_ONE     = LEN_WIDTH'(1);

  // Entry layout: {term_flag, data}
  logic [DATA_WIDTH:0]     r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]         r_wptr;
  logic [c_AW-1:0]         r_rptr;
  logic [c_CW-1:0]         r_count;
  logic                    r_flush_pending;
  logic                    r_overflow;
  logic                    r_afull;

  logic [DATA_WIDTH-1:0]   r_tdata;
  logic [c_KEEP_W-1:0]     r_tkeep;
  logic                    r_tlast;
  logic                    r_tvalid;
  logic [LEN_WIDTH-1:0]    r_beat_cnt;
  logic [LEN_WIDTH-1:0]    r_len_q;
  logic [LEN_WIDTH-1:0]    r_pkt_count;

  logic                    w_full;
  logic                    w_empty;
  logic                    w_out_free;
  logic                    w_pop;
  logic                    w_wr_beat;
  logic                    w_wr_term;
  logic                    w_push;
  logic                    w_drop;
  logic [DATA_WIDTH:0]     w_wr_entry;
  logic [DATA_WIDTH:0]     w_head;
  logic [LEN_WIDTH-1:0]    w_len_eff;
  logic                    w_data_last;

  assign w_full     = (r_count == c_FULL_LEVEL);
  assign w_empty    = (r_count == '0);
  assign w_out_free = !r_tvalid || M_AXIS_RDATA_tready;
  assign w_pop      = !w_empty && w_out_free;
  assign w_wr_beat  = rd_valid && (!w_full || w_pop);
  assign w_drop     = rd_valid && !w_wr_beat;
  // The terminator only takes an idle write slot, so it always trails any
  // beat that arrived alongside the flush request.
  assign w_wr_term  = r_flush_pending && !rd_valid && !w_full;
  assign w_push     = w_wr_beat || w_wr_term;
  assign w_wr_entry = w_wr_beat ? {1'b0, rd_data} : {1'b1, {DATA_WIDTH{1'b0}}};
  assign w_head     = r_mem[r_rptr];

  // Length is latched at the first beat of a packet; later edits wait a packet.
  assign w_len_eff   = (r_beat_cnt == '0) ? pkt_len : r_len_q;
  assign w_data_last = (w_len_eff != '0) && (r_beat_cnt == w_len_eff - c_LEN_ONE);

  always_ff @(posedge c0_ddr4_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_wr_entry;
    end
  end

  always_ff @(posedge c0_ddr4_clk or posedge c0_ddr4_rst) begin
    if (c0_ddr4_rst) begin
      r_wptr          <= '0;
      r_rptr          <= '0;
      r_count         <= '0;
      r_flush_pending <= 1'b0;
      r_overflow      <= 1'b0;
      r_afull         <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + c_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
      // A flush seen while one is already pending folds into it.
      r_flush_pending <= (r_flush_pending && !w_wr_term) || (flush && !r_flush_pending);
      if (w_drop)       r_overflow <= 1'b1;
      else if (clr_err) r_overflow <= 1'b0;
      r_afull <= (r_count >= c_AFULL_LEVEL);
    end
  end

  always_ff @(posedge c0_ddr4_clk or posedge c0_ddr4_rst) begin
    if (c0_ddr4_rst) begin
      r_tdata     <= '0;
      r_tkeep     <= '0;
      r_tlast     <= 1'b0;
      r_tvalid    <= 1'b0;
      r_beat_cnt  <= '0;
      r_len_q     <= '0;
      r_pkt_count <= '0;
    end else begin
      if (w_pop) begin
        if (w_head[DATA_WIDTH]) begin
          // Terminator on an already-closed packet is swallowed silently.
          if (r_beat_cnt != '0) begin
            r_tdata  <= '0;
            r_tkeep  <= '0;
            r_tlast  <= 1'b1;
            r_tvalid <= 1'b1;
          end else begin
            r_tvalid <= 1'b0;
          end
          r_beat_cnt <= '0;
        end else begin
          r_tdata  <= w_head[DATA_WIDTH-1:0];
          r_tkeep  <= '1;
          r_tlast  <= w_data_last;
          r_tvalid <= 1'b1;
          if (r_beat_cnt == '0) r_len_q <= pkt_len;
          r_beat_cnt <= w_data_last ? '0 : r_beat_cnt + c_LEN_ONE;
        end
      end else if (r_tvalid && M_AXIS_RDATA_tready) begin
        r_tvalid <= 1'b0;
      end
      if (r_tvalid && M_AXIS_RDATA_tready && r_tlast) begin
        r_pkt_count <= r_pkt_count + c_LEN_ONE;
      end
    end
  end

  assign M_AXIS_RDATA_tdata  = r_tdata;
  assign M_AXIS_RDATA_tkeep  = r_tkeep;
  assign M_AXIS_RDATA_tlast  = r_tlast;
  assign M_AXIS_RDATA_tvalid = r_tvalid;
  assign rd_afull            = r_afull;
  assign overflow            = r_overflow;
  assign pkt_count           = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_rdata_stream_packetizer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_rdata_stream_packetizer
// Purpose  : Scoreboard bench for rdata_stream_packetizer (directed vectors).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rdata_stream_packetizer;

  localparam int DW = 512;
  localparam int KW = DW / 8;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [LW-1:0] pkt_len;
  logic          flush;
  logic          clr_err;
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic          tlast;
  logic          tvalid;
  logic          tready;
  logic          rd_afull;
  logic          overflow;
  logic [LW-1:0] pkt_count;

  logic tready_fixed = 1'b1;
  logic rand_mode    = 1'b0;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_pkts = 0;

  rdata_stream_packetizer #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(64), .AFULL_MARGIN(8), .LEN_WIDTH(LW)
  ) dut (
    .c0_ddr4_clk        (clk),
    .c0_ddr4_rst        (rst),
    .rd_valid           (rd_valid),
    .rd_data            (rd_data),
    .pkt_len            (pkt_len),
    .flush              (flush),
    .clr_err            (clr_err),
    .M_AXIS_RDATA_tdata (tdata),
    .M_AXIS_RDATA_tkeep (tkeep),
    .M_AXIS_RDATA_tlast (tlast),
    .M_AXIS_RDATA_tvalid(tvalid),
    .M_AXIS_RDATA_tready(tready),
    .rd_afull           (rd_afull),
    .overflow           (overflow),
    .pkt_count          (pkt_count)
  );

  initial forever #5 clk = ~clk;

  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tready = rand_mode ? 1'($urandom_range(0, 1)) : tready_fixed;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    exp_t e;
    e.data = d;
    e.keep = k;
    e.last = l;
    exp_q.push_back(e);
    if (l) exp_pkts++;
  endtask

  task automatic drive_beat(input logic [DW-1:0] d);
    rd_valid = 1'b1;
    rd_data  = d;
    @(posedge clk);
    #1;
    rd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({name, "_drain_left"}, 64'(exp_q.size()), 64'd0);
    idle(3);
    check({name, "_pkt_count"}, 64'(pkt_count), 64'(exp_pkts));
  endtask

  // Monitor: pops the scoreboard on each handshake and checks AXIS hold rules.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic [KW-1:0] prev_keep;
  logic          prev_last;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          n_checks++;
          if (!(tvalid === 1'b1 && tdata === prev_data && tkeep === prev_keep && tlast === prev_last)) begin
            n_errors++;
            $display("FAIL hold: got valid=%b last=%b data_lo=%h required valid=1 last=%b data_lo=%h",
                     tvalid, tlast, tdata[63:0], prev_last, prev_data[63:0]);
          end
        end
        if (tvalid && tready) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_beat: got data_lo=%h keep=%h last=%b required no beat",
                     tdata[63:0], tkeep, tlast);
          end else begin
            e = exp_q.pop_front();
            if (tdata !== e.data || tkeep !== e.keep || tlast !== e.last) begin
              n_errors++;
              $display("FAIL beat: got data=%h keep=%h last=%b required data=%h keep=%h last=%b",
                       tdata, tkeep, tlast, e.data, e.keep, e.last);
            end
          end
        end
        prev_stall = tvalid && !tready;
        prev_data  = tdata;
        prev_keep  = tkeep;
        prev_last  = tlast;
      end
    end
  end

  initial begin
    int sent;
    int guard;
    rst = 1'b1; rd_valid = 1'b0; rd_data = '0; pkt_len = '0; flush = 1'b0; clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_tdata_zero", 64'(tdata == '0), 64'd1);
    check("rst_tkeep", 64'(tkeep), 64'd0);
    check("rst_tlast", 64'(tlast), 64'd0);
    check("rst_afull", 64'(rd_afull), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_pkt_count", 64'(pkt_count), 64'd0);
    rst = 1'b0;
    idle(2);

    // Length-framed packets of 4 beats.
    pkt_len = 16'd4;
    drive_beat(DW'(0));
    push_exp(DW'(0), '1, 1'b0);
    check("t1_latency_early", 64'(tvalid), 64'd0);
    for (int i = 1; i < 8; i++) begin
      drive_beat(DW'(i));
      push_exp(DW'(i), '1, (i % 4) == 3);
      if (i == 1) check("t1_latency_valid", 64'(tvalid), 64'd1);
    end
    drain("t1");

    // Unbounded packet closed by flush -> empty tlast beat.
    pkt_len = 16'd0;
    for (int i = 0; i < 3; i++) begin
      drive_beat(DW'(100 + i));
      push_exp(DW'(100 + i), '1, 1'b0);
    end
    pulse_flush();
    push_exp('0, '0, 1'b1);
    drain("t2");

    // Flush after a length-closed packet: terminator is swallowed.
    pkt_len = 16'd2;
    for (int i = 0; i < 2; i++) begin
      drive_beat(DW'(200 + i));
      push_exp(DW'(200 + i), '1, i == 1);
    end
    pulse_flush();
    drain("t3");
    idle(5);
    check("t3_no_extra", 64'(pkt_count), 64'(exp_pkts));

    // Fill past capacity with the sink stalled.
    pkt_len = 16'd0;
    tready_fixed = 1'b0;
    idle(2);
    for (int i = 0; i < 70; i++) begin
      drive_beat(DW'(1000 + i));
      if (i < 65) push_exp(DW'(1000 + i), '1, 1'b0);
      if (i == 56) check("t4_afull_below", 64'(rd_afull), 64'd0);
      if (i == 57) check("t4_afull_at56", 64'(rd_afull), 64'd1);
      if (i == 64) check("t4_no_overflow_yet", 64'(overflow), 64'd0);
      if (i == 65) check("t4_overflow_set", 64'(overflow), 64'd1);
    end
    check("t4_overflow_sticky", 64'(overflow), 64'd1);
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    check("t4_clr_err", 64'(overflow), 64'd0);
    tready_fixed = 1'b1;
    drain("t4");
    check("t4_afull_clear", 64'(rd_afull), 64'd0);
    pulse_flush();
    push_exp('0, '0, 1'b1);
    drain("t4_close");

    // Random backpressure, 7-beat packets, scheduler honours rd_afull.
    pkt_len = 16'd7;
    rand_mode = 1'b1;
    sent = 0;
    guard = 0;
    while (sent < 200 && guard < 5000) begin
      guard++;
      if (rd_afull) begin
        idle(1);
      end else begin
        drive_beat(DW'(2000 + sent));
        push_exp(DW'(2000 + sent), '1, (sent % 7) == 6);
        sent++;
      end
    end
    check("t5_sent", 64'(sent), 64'd200);
    check("t5_no_overflow", 64'(overflow), 64'd0);
    rand_mode = 1'b0;
    tready_fixed = 1'b1;
    drain("t5");

    // Reset with beats buffered, then a clean 4-beat packet.
    pkt_len = 16'd4;
    tready_fixed = 1'b0;
    idle(2);
    for (int i = 0; i < 10; i++) drive_beat(DW'(3000 + i));
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_tvalid", 64'(tvalid), 64'd0);
    check("t6_rst_afull", 64'(rd_afull), 64'd0);
    check("t6_rst_pkt_count", 64'(pkt_count), 64'd0);
    exp_q.delete();
    exp_pkts = 0;
    idle(2);
    rst = 1'b0;
    tready_fixed = 1'b1;
    idle(2);
    for (int i = 0; i < 4; i++) begin
      drive_beat(DW'(4000 + i));
      push_exp(DW'(4000 + i), '1, i == 3);
    end
    drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
